// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sprite ROM port among NREQ draw stages.
// The granted address is registered to the ROM and each word returns to its owner with a one-hot strobe.
module sprite_rom_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 12,
    parameter int ROM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] addr_in,
    output logic [NREQ-1:0]        gnt,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [DATA_W-1:0]      rom_data,
    output logic [NREQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]      rd_data
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0]  ptr;
    logic [NREQ-1:0]   eligible;
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [NREQ-1:0]   win_onehot;
    logic [ADDR_W-1:0] win_addr;
    logic [PTR_W:0]    cand;
    logic [NREQ-1:0]   tag [ROM_LAT];

    // The current grant holder only updates req/addr at this edge, so it sits out one round.
    assign eligible = req & ~gnt;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NREQ))
                cand = cand - (PTR_W+1)'(NREQ);
            if (!win_found && eligible[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_addr   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (win_found && (win_idx == PTR_W'(j))) begin
                win_onehot[j] = 1'b1;
                win_addr      = addr_in[j*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= '0;
            rom_addr <= '0;
            ptr      <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
            for (int k = 0; k < ROM_LAT; k++)
                tag[k] <= '0;
        end else begin
            gnt <= win_onehot;
            if (win_found) begin
                rom_addr <= win_addr;
                ptr      <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
            end
            // Tag pipeline tracks the owner of each read while the ROM works on it.
            tag[0] <= gnt;
            for (int k = 1; k < ROM_LAT; k++)
                tag[k] <= tag[k-1];
            rd_valid <= tag[ROM_LAT-1];
            rd_data  <= rom_data;
        end
    end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Round-robin arbiter sharing one synchronous-read sprite/texture ROM port among NREQ pixel-drawing requesters, e.g. tank, turret, projectile and map-tile draw stages in the 1024x768 pipeline.
- Registers the granted address to the ROM and tracks in-flight reads through a ROM_LAT-deep tag pipeline.
- Returns each ROM word to its owner with a one-hot valid strobe.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 12, ROM address width.
- DATA_W, 12, ROM word width (RGB 4:4:4).
- ROM_LAT, 1, ROM read latency in cycles, from rom_addr registered to rom_data valid (1..4).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester read request, level.
- addr_in  in  NREQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  out  NREQ  registered one-hot grant, high for one cycle.
- rom_addr  out  ADDR_W  registered address to the ROM.
- rom_data  in  DATA_W  ROM read data.
- rd_valid  out  NREQ  one-hot data-return strobe.
- rd_data  out  DATA_W  returned ROM word.

Behaviour:
Reset
- Synchronous. Clears gnt=0, rom_addr=0, rd_valid=0, rd_data=0, RR pointer=0 and every tag-pipeline stage.
- Reads already in flight are discarded; no rd_valid is produced for them.

Arbitration, evaluated at each rising edge with rst low
- eligible = req & ~gnt. The requester holding gnt this cycle is masked for one edge, because it only updates req/addr at that same edge.
- Winner = first eligible index searching ptr, ptr+1, ..., wrapping modulo NREQ.
- If there is a winner w: gnt <= onehot(w); rom_addr <= addr_in[w]; ptr <= (w+1) mod NREQ.
- If there is none: gnt <= 0; rom_addr holds its value; ptr unchanged.
- At most one grant per cycle. Grants can be issued on back-to-back cycles to different requesters.
- A single requester is granted at most every other cycle.
- Starvation bound: a requester holding req continuously is granted within NREQ edges.

Requester contract
- Hold req and addr_in stable until the edge at which it observes gnt[i]=1.
- At that edge it may drop req or present the next address with req held.
- Dropping req before being granted withdraws the request; no grant or data follows.

Data return
- tag pipeline stage 0 <= gnt.
- Stage k <= stage k-1, for ROM_LAT stages.
- rd_valid <= tag from the final stage.
- rd_data <= rom_data, registered on the same edge.
- End-to-end latency: gnt high in cycle t, then rd_valid high in cycle t+ROM_LAT+1.
- rd_data is updated every cycle and is meaningful only while rd_valid is nonzero.
- rd_valid is always one-hot or zero.

Boundary conditions
- All req high: grants rotate 0,1,2,3,0,...
- Simultaneous req rising on all inputs from idle with ptr=0: requester 0 wins.
- ptr wraps from NREQ-1 to 0.
- An addr_in change by a non-granted requester has no effect.
- Reset mid-stream: no grant or rd_valid in the cycle after reset is deasserted.

Test Plan:
- Idle start, ROM_LAT=1, req=4'b0010, addr1=12'h0A5 -> gnt=4'b0010 one cycle after the edge; rom_addr=12'h0A5; rd_valid=4'b0010 exactly 2 cycles after gnt, with rd_data equal to the model ROM[0x0A5].
- req=4'b1111 held for 8 cycles, addresses 0x100..0x103 -> gnt sequence 0001,0010,0100,1000,0001,...; rd_valid repeats the same sequence shifted by ROM_LAT+1; each rd_data matches its owner's address.
- Only requester 2 holds req continuously with address incrementing on each grant -> gnt[2] on alternating cycles; addresses 0x200,0x201,0x202 returned in order.
- ptr=3 (last grant to 2), then req=4'b1001 -> requester 3 granted first, requester 0 next.
- ROM_LAT=3, grants in flight, rst pulsed for 1 cycle -> every output is 0 in the cycle after the reset edge, and no stale rd_valid appears afterwards.
- Requester 1 raises req and drops it before winning because requester 0 was higher in the rotation -> no gnt[1] and no rd_valid[1].
